// File: rtl/hot_track_pkg.sv
// Shared definitions between the hotness tracker and its migration requester.
// Query opcodes, requester FSM states and default bus geometry.
package hot_track_pkg;

  localparam int ADDR_SIZE_DEF = 28;
  localparam int CNT_SIZE_DEF  = 13;
  localparam int CMD_WIDTH_DEF = 4;
  localparam int TOP_K_DEF     = 5;

  localparam logic [CMD_WIDTH_DEF-1:0] QUERY_IDLE  = 4'd0;
  localparam logic [CMD_WIDTH_DEF-1:0] QUERY_MIG   = 4'd1;
  localparam logic [CMD_WIDTH_DEF-1:0] QUERY_FLUSH = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUERY,
    ST_WAIT_TOPK,
    ST_DRAIN
  } mig_state_e;

endpackage

// File: rtl/mig_interval_timer.sv
// Free-running interval timer: one-cycle expire pulse every max(interval,1) enabled cycles.
// Combinational expire on the terminal count; clear or !enable forces the count back to 0.
module mig_interval_timer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] interval,
  input  logic        clear,
  output logic        expire
);

  logic [31:0] count_q, count_d;
  logic [31:0] term;

  always_comb begin
    term    = (interval == 32'd0) ? 32'd0 : interval - 32'd1;
    count_d = count_q;
    expire  = 1'b0;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q >= term) begin
      // >= so that shrinking the interval mid-count still expires promptly
      count_d = '0;
      expire  = 1'b1;
    end else begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/hot_mig_requester.sv
// Periodically queries the hotness tracker for its top-k lines and streams eligible addresses
// to the migration engine with valid/ready; flush requests are latched and take priority.
module hot_mig_requester
  import hot_track_pkg::*;
#(
  parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int CNT_SIZE   = CNT_SIZE_DEF,
  parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
  parameter int TOP_K      = TOP_K_DEF,
  parameter int TMO_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cfg_enable,
  input  logic [31:0]                   cfg_interval,
  input  logic [2:0]                    cfg_num_mig,
  input  logic [CNT_SIZE-1:0]           cfg_cnt_threshold,
  input  logic                          flush_req,
  output logic                          query_en,
  output logic [CMD_WIDTH-1:0]          query_cmd,
  input  logic                          query_ready,
  output logic [2:0]                    num_mig,
  input  logic                          mig_en,
  input  logic [TOP_K*ADDR_SIZE-1:0]    top_addr,
  input  logic [TOP_K*CNT_SIZE-1:0]     top_cnt,
  output logic                          mig_addr_valid,
  output logic [ADDR_SIZE-1:0]          mig_addr,
  input  logic                          mig_addr_ready,
  output logic                          busy,
  output logic [31:0]                   mig_issued_cnt,
  output logic [15:0]                   timeout_cnt
);

  localparam int              TMO_W    = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [2:0]      TOPK_N   = (TOP_K > 7) ? 3'd7 : 3'(TOP_K);

  mig_state_e         state_q, state_d;
  logic               flush_pend_q, flush_pend_d;
  logic               mig_pend_q, mig_pend_d;
  logic               is_flush_q, is_flush_d;
  logic [2:0]         num_mig_q, num_mig_d;
  logic [2:0]         idx_q, idx_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic [31:0]        issued_q, issued_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               capture;
  logic               timer_expire;

  logic [ADDR_SIZE-1:0] slot_addr_q [TOP_K];
  logic [CNT_SIZE-1:0]  slot_cnt_q  [TOP_K];

  logic [2:0]          eff_num;
  logic [CNT_SIZE-1:0] cur_cnt;
  logic                eligible;
  logic                last_slot;

  mig_interval_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (cfg_enable),
    .interval (cfg_interval),
    .clear    (state_q != ST_IDLE),
    .expire   (timer_expire)
  );

  assign eff_num   = (cfg_num_mig > TOPK_N) ? TOPK_N : cfg_num_mig;
  assign cur_cnt   = slot_cnt_q[idx_q];
  assign eligible  = (cur_cnt != '0) && (cur_cnt >= cfg_cnt_threshold);
  assign last_slot = ({1'b0, idx_q} + 4'd1) >= {1'b0, num_mig_q};

  always_comb begin
    state_d        = state_q;
    flush_pend_d   = flush_pend_q | flush_req;
    mig_pend_d     = mig_pend_q | timer_expire;
    is_flush_d     = is_flush_q;
    num_mig_d      = num_mig_q;
    idx_d          = idx_q;
    wait_d         = wait_q;
    issued_d       = issued_q;
    tmo_d          = tmo_q;
    capture        = 1'b0;
    query_en       = 1'b0;
    query_cmd      = CMD_WIDTH'(QUERY_IDLE);
    mig_addr_valid = 1'b0;
    mig_addr       = '0;
    unique case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        idx_d  = '0;
        // Same-cycle request/expiry are honoured directly so no cycle is lost to the flags.
        if (flush_pend_q || flush_req) begin
          state_d    = ST_QUERY;
          is_flush_d = 1'b1;
          num_mig_d  = eff_num;
        end else if (mig_pend_q || timer_expire) begin
          if (eff_num != 3'd0) begin
            state_d    = ST_QUERY;
            is_flush_d = 1'b0;
            num_mig_d  = eff_num;
          end else begin
            mig_pend_d = 1'b0;
          end
        end
      end
      ST_QUERY: begin
        query_en  = 1'b1;
        query_cmd = is_flush_q ? CMD_WIDTH'(QUERY_FLUSH) : CMD_WIDTH'(QUERY_MIG);
        if (query_ready) begin
          if (is_flush_q) begin
            flush_pend_d = flush_req;
            state_d      = ST_IDLE;
          end else begin
            mig_pend_d = 1'b0;
            state_d    = ST_WAIT_TOPK;
          end
        end
      end
      ST_WAIT_TOPK: begin
        if (mig_en) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else if (wait_q >= TMO_LAST) begin
          state_d = ST_IDLE;
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (eligible) begin
          mig_addr_valid = 1'b1;
          mig_addr       = slot_addr_q[idx_q];
        end
        if (!eligible || mig_addr_ready) begin
          if (eligible) issued_d = issued_q + 32'd1;
          if (last_slot) state_d = ST_IDLE;
          else           idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
      mig_pend_q   <= 1'b0;
      is_flush_q   <= 1'b0;
      num_mig_q    <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      issued_q     <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      mig_pend_q   <= mig_pend_d;
      is_flush_q   <= is_flush_d;
      num_mig_q    <= num_mig_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      issued_q     <= issued_d;
      tmo_q        <= tmo_d;
    end
  end

  // Slots beyond the requested count are zeroed so they can never look eligible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TOP_K; i++) begin
        slot_addr_q[i] <= '0;
        slot_cnt_q[i]  <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < TOP_K; i++) begin
        if (i < int'(num_mig_q)) begin
          slot_addr_q[i] <= top_addr[i*ADDR_SIZE +: ADDR_SIZE];
          slot_cnt_q[i]  <= top_cnt[i*CNT_SIZE +: CNT_SIZE];
        end else begin
          slot_addr_q[i] <= '0;
          slot_cnt_q[i]  <= '0;
        end
      end
    end
  end

  assign num_mig        = num_mig_q;
  assign busy           = (state_q != ST_IDLE);
  assign mig_issued_cnt = issued_q;
  assign timeout_cnt    = tmo_q;

endmodule

// File: tb/tb_hot_mig_requester.sv
// Bench for hot_mig_requester: directed scenarios plus randomized top-k drains checked
// against a list model of which slots should be emitted.
module tb_hot_mig_requester;
  import hot_track_pkg::*;

  localparam int AW  = 28;
  localparam int CW  = 13;
  localparam int KW  = 4;
  localparam int TK  = 5;
  localparam int TMO = 255;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_enable;
  logic [31:0]       cfg_interval;
  logic [2:0]        cfg_num_mig;
  logic [CW-1:0]     cfg_cnt_threshold;
  logic              flush_req;
  logic              query_en;
  logic [KW-1:0]     query_cmd;
  logic              query_ready;
  logic [2:0]        num_mig;
  logic              mig_en;
  logic [TK*AW-1:0]  top_addr;
  logic [TK*CW-1:0]  top_cnt;
  logic              mig_addr_valid;
  logic [AW-1:0]     mig_addr;
  logic              mig_addr_ready;
  logic              busy;
  logic [31:0]       mig_issued_cnt;
  logic [15:0]       timeout_cnt;

  always #5 clk = ~clk;

  hot_mig_requester #(
    .ADDR_SIZE(AW), .CNT_SIZE(CW), .CMD_WIDTH(KW), .TOP_K(TK), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .cfg_interval(cfg_interval),
    .cfg_num_mig(cfg_num_mig), .cfg_cnt_threshold(cfg_cnt_threshold), .flush_req(flush_req),
    .query_en(query_en), .query_cmd(query_cmd), .query_ready(query_ready), .num_mig(num_mig),
    .mig_en(mig_en), .top_addr(top_addr), .top_cnt(top_cnt), .mig_addr_valid(mig_addr_valid),
    .mig_addr(mig_addr), .mig_addr_ready(mig_addr_ready), .busy(busy),
    .mig_issued_cnt(mig_issued_cnt), .timeout_cnt(timeout_cnt)
  );

  int nvec = 0;
  int nerr = 0;

  logic [AW-1:0] s_addr [TK];
  logic [CW-1:0] s_cnt  [TK];
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] got_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the first min(n, TOP_K) slots whose count is nonzero and meets the threshold.
  task automatic build_expect(input int n, input int thr);
    int eff;
    eff = (n > TK) ? TK : n;
    exp_q.delete();
    for (int i = 0; i < eff; i++)
      if (s_cnt[i] != 0 && int'(s_cnt[i]) >= thr) exp_q.push_back(s_addr[i]);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cfg_enable = 1'b0; cfg_interval = 32'd10; cfg_num_mig = 3'd2; cfg_cnt_threshold = '0;
    flush_req = 1'b0; query_ready = 1'b1; mig_en = 1'b0; top_addr = '0; top_cnt = '0;
    mig_addr_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_topk();
    for (int i = 0; i < TK; i++) begin
      top_addr[i*AW +: AW] = s_addr[i];
      top_cnt[i*CW +: CW]  = s_cnt[i];
    end
    mig_en = 1'b1;
    @(negedge clk);
    mig_en = 1'b0;
  endtask

  task automatic wait_query(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (query_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  // Enables the timer, waits for the MIG query and returns on the first WAIT_TOPK cycle.
  task automatic trigger(input int interval, input string tag);
    int  cyc;
    bit  ok;
    cfg_interval = interval;
    cfg_enable = 1'b1;
    wait_query(cyc, ok);
    chk({tag, "_query_seen"}, ok, 1);
    chk({tag, "_query_cmd"}, query_cmd, QUERY_MIG);
    cfg_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect(input bit rnd, input string tag);
    bit done;
    done = 1'b0;
    got_q.delete();
    for (int c = 0; c < 200; c++) begin
      mig_addr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mig_addr_valid && mig_addr_ready) got_q.push_back(mig_addr);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    mig_addr_ready = 1'b1;
    chk({tag, "_drain_done"}, done, 1);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_addr"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  ok;
    int  n;
    int  base;
    int  nm;
    int  th;

    // Reset values
    do_reset();
    chk("rst_query_en", query_en, 0);
    chk("rst_query_cmd", query_cmd, 0);
    chk("rst_num_mig", num_mig, 0);
    chk("rst_valid", mig_addr_valid, 0);
    chk("rst_addr", mig_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issued", mig_issued_cnt, 0);
    chk("rst_timeout", timeout_cnt, 0);

    // Timer: interval 10, query 10 cycles after enable, two slots drained in order
    cfg_interval = 32'd10; cfg_num_mig = 3'd2; cfg_cnt_threshold = 13'd1;
    cfg_enable = 1'b1;
    wait_query(cyc, ok);
    chk("tmr_seen", ok, 1);
    chk("tmr_latency", cyc, 10);
    chk("tmr_cmd", query_cmd, QUERY_MIG);
    chk("tmr_num_mig", num_mig, 2);
    cfg_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    s_addr[0] = 28'h0A0_0000; s_addr[1] = 28'h0B1_1111; s_addr[2] = 28'h1; s_addr[3] = 28'h2;
    s_addr[4] = 28'h3;
    s_cnt[0] = 13'd9; s_cnt[1] = 13'd5; s_cnt[2] = 13'd8; s_cnt[3] = 13'd8; s_cnt[4] = 13'd8;
    drive_topk();
    build_expect(2, 1);
    collect(1'b0, "tmr");
    compare_q("tmr");
    chk("tmr_issued", mig_issued_cnt, 2);

    // Skip: zero and below-threshold counts are not emitted
    do_reset();
    cfg_num_mig = 3'd3; cfg_cnt_threshold = 13'd4;
    trigger(1, "skip");
    s_addr[0] = 28'h123_4567; s_addr[1] = 28'h222_2222; s_addr[2] = 28'h333_3333;
    s_cnt[0] = 13'd7; s_cnt[1] = 13'd0; s_cnt[2] = 13'd3; s_cnt[3] = 13'd9; s_cnt[4] = 13'd9;
    drive_topk();
    build_expect(3, 4);
    collect(1'b0, "skip");
    compare_q("skip");
    chk("skip_issued", mig_issued_cnt, 1);

    // Backpressure: ready low for 5 cycles holds the request for 6
    do_reset();
    cfg_num_mig = 3'd1; cfg_cnt_threshold = 13'd1;
    trigger(1, "bp");
    s_addr[0] = 28'h0DE_ADBE; s_cnt[0] = 13'd5;
    drive_topk();
    base = mig_issued_cnt;
    for (int k = 0; k < 6; k++) begin
      mig_addr_ready = (k == 5);
      chk("bp_hold", {mig_addr_valid, mig_addr}, {1'b1, s_addr[0]});
      @(negedge clk);
    end
    mig_addr_ready = 1'b1;
    chk("bp_done", busy, 0);
    chk("bp_issued", mig_issued_cnt, base + 1);

    // Flush priority: flush_req in the expiry cycle
    do_reset();
    cfg_interval = 32'd10; cfg_num_mig = 3'd2;
    cfg_enable = 1'b1;
    repeat (9) @(negedge clk);
    chk("fl_no_early_query", query_en, 0);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    cfg_enable = 1'b0;
    chk("fl_first_en", query_en, 1);
    chk("fl_first_cmd", query_cmd, QUERY_FLUSH);
    @(negedge clk);
    chk("fl_back_idle", busy, 0);
    wait_query(cyc, ok);
    chk("fl_mig_seen", ok, 1);
    chk("fl_mig_cmd", query_cmd, QUERY_MIG);

    // Timeout and clamp
    do_reset();
    cfg_num_mig = 3'd7;
    cfg_interval = 32'd1;
    cfg_enable = 1'b1;
    wait_query(cyc, ok);
    chk("tmo_seen", ok, 1);
    chk("tmo_clamp", num_mig, TK);
    cfg_enable = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("tmo_wait_cycles", n, TMO);
    chk("tmo_count", timeout_cnt, 1);

    // Reset mid-DRAIN: first slot accepted, second stalled, then reset
    do_reset();
    cfg_num_mig = 3'd2; cfg_cnt_threshold = 13'd1;
    trigger(1, "rd");
    s_addr[0] = 28'h0AA_AAAA; s_addr[1] = 28'h0BB_BBBB; s_cnt[0] = 13'd4; s_cnt[1] = 13'd4;
    drive_topk();
    mig_addr_ready = 1'b1;
    @(negedge clk);
    mig_addr_ready = 1'b0;
    chk("rd_valid_before", mig_addr_valid, 1);
    chk("rd_issued_before", mig_issued_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rd_valid_drop", mig_addr_valid, 0);
    chk("rd_busy", busy, 0);
    chk("rd_issued_clr", mig_issued_cnt, 0);
    chk("rd_addr_clr", mig_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    mig_addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rd_no_replay", mig_addr_valid, 0);
    chk("rd_issued_after", mig_issued_cnt, 0);
    chk("rd_timeout_after", timeout_cnt, 0);

    // Randomized drains
    do_reset();
    for (int it = 0; it < 24; it++) begin
      nm = $urandom_range(0, 7);
      th = $urandom_range(0, 12);
      cfg_num_mig = 3'(nm);
      cfg_cnt_threshold = CW'(th);
      for (int i = 0; i < TK; i++) begin
        s_addr[i] = AW'($urandom);
        s_cnt[i]  = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 15));
      end
      drive_topk();
      chk("rnd_spurious_mig_en", busy, 0);
      if (nm == 0) begin
        cfg_interval = 32'd2;
        cfg_enable = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (query_en || busy) ok = 1'b1;
        end
        cfg_enable = 1'b0;
        chk("rnd_zero_no_query", ok, 0);
      end else begin
        base = mig_issued_cnt;
        trigger($urandom_range(1, 6), "rnd");
        chk("rnd_num_mig", num_mig, (nm > TK) ? TK : nm);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drive_topk();
        build_expect(nm, th);
        collect(1'b1, "rnd");
        compare_q("rnd");
        chk("rnd_issued", mig_issued_cnt, base + exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hot_mig_requester.md
HOT_MIG_REQUESTER -- requirements
Module: hot_mig_requester

Interface
REQ-001 SHALL have parameters: ADDR_SIZE, default 28, cache-line address width; CNT_SIZE, default 13, hotness count width; CMD_WIDTH, default 4, query opcode width; TOP_K, default 5, number of top-k slots; TMO_CYCLES, default 255, WAIT_TOPK timeout.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  periodic migration queries enabled.
- cfg_interval  in  32  cycles between queries.
- cfg_num_mig  in  3  requested entries per query.
- cfg_cnt_threshold  in  CNT_SIZE  minimum count for migration.
- flush_req  in  1  single-cycle pulse requesting a tracker flush.
- query_en  out  1  query request to the tracker.
- query_cmd  out  CMD_WIDTH  opcode: 1=MIG, 2=FLUSH.
- query_ready  in  1  tracker accepted the query.
- num_mig  out  3  entry count driven to the tracker.
- mig_en  in  1  top-k outputs valid this cycle.
- top_addr  in  TOP_K*ADDR_SIZE  slot i at bits [i*ADDR_SIZE +: ADDR_SIZE], slot 0 hottest.
- top_cnt  in  TOP_K*CNT_SIZE  slot i counts, same packing.
- mig_addr_valid  out  1  migration request valid.
- mig_addr  out  ADDR_SIZE  address to migrate.
- mig_addr_ready  in  1  migration engine accepts.
- busy  out  1  state is not IDLE.
- mig_issued_cnt  out  32  addresses accepted downstream.
- timeout_cnt  out  16  WAIT_TOPK timeouts.

Function
REQ-003 SHALL implement FSM states IDLE, QUERY, WAIT_TOPK, DRAIN.
REQ-004 IDLE: interval timer SHALL increment each cycle while cfg_enable=1; when it reaches max(cfg_interval,1)-1 it SHALL clear and set a sticky mig_pending flag.
REQ-005 flush_req SHALL set a sticky flush_pending flag in any state.
REQ-006 IDLE exit: if flush_pending, go to QUERY with cmd FLUSH; else if mig_pending and effective num_mig>0, go to QUERY with cmd MIG. Flush wins when both flags are set.
REQ-007 Effective num_mig SHALL be min(cfg_num_mig, TOP_K), latched on IDLE->QUERY. num_mig SHALL hold that value until the next return to IDLE.
REQ-008 If effective num_mig is 0, mig_pending SHALL clear and no query SHALL be issued.
REQ-009 QUERY: query_en=1 and query_cmd SHALL be held stable until the cycle in which query_ready=1. In that cycle the handshake completes. query_en SHALL be 0 from the next cycle.
REQ-010 On QUERY handshake: FLUSH SHALL clear flush_pending and go to IDLE; MIG SHALL clear mig_pending and go to WAIT_TOPK.
REQ-011 WAIT_TOPK: on mig_en=1, the first num_mig slots of top_addr/top_cnt SHALL be captured into internal registers and the FSM SHALL go to DRAIN.
REQ-012 WAIT_TOPK: if no mig_en within TMO_CYCLES cycles, the FSM SHALL go to IDLE and increment timeout_cnt, saturating.
REQ-013 DRAIN: slots SHALL be scanned in order 0..num_mig-1. A slot SHALL be skipped (one cycle, no valid) if its count is 0 or below cfg_cnt_threshold.
REQ-014 DRAIN: for an eligible slot, mig_addr_valid=1 with mig_addr stable until mig_addr_ready=1. On the accept cycle the FSM SHALL advance to the next slot and increment mig_issued_cnt (wrapping).
REQ-015 After the last slot the FSM SHALL return to IDLE. The interval timer SHALL restart from 0 on this return.
REQ-016 Clearing cfg_enable SHALL stop and clear the timer. An in-flight QUERY/WAIT_TOPK/DRAIN SHALL complete normally. A pending flush SHALL still be serviced.
REQ-017 mig_en outside WAIT_TOPK SHALL be ignored.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 On rstn=0, asynchronously:
- state SHALL be IDLE.
- timer, flags and captured slots SHALL clear.
- query_en, query_cmd, num_mig, mig_addr_valid, mig_addr, busy, mig_issued_cnt and timeout_cnt SHALL be 0.
REQ-020 Reset asserted mid-DRAIN SHALL drop mig_addr_valid immediately. No partial request SHALL be replayed after reset.

Structure
REQ-021 The shared package hot_track_pkg SHALL hold the QUERY_IDLE/MIG/FLUSH opcodes, the FSM state enum and the default ADDR_SIZE/CNT_SIZE/CMD_WIDTH/TOP_K constants, shared with the tracker.
REQ-022 The interval timer SHALL be one sub-module, mig_interval_timer (inputs: enable, interval, clear; output: expire pulse). All other logic SHALL stay flat.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Timer: cfg_interval=10, cfg_num_mig=2, threshold=1, query_ready tied 1, mig_en 2 cycles after query, cnts {9,5}, mig_addr_ready tied 1 -> query_en with cmd=1 at 10 cycles after enable, mig_addr 0th then 1st slot, mig_issued_cnt=2.
- Skip: cnts {7,0,3}, threshold=4, num_mig=3 -> only slot 0 emitted, mig_issued_cnt=1.
- Backpressure: mig_addr_ready low for 5 cycles -> mig_addr_valid and mig_addr stable for 6 cycles, one count increment.
- Flush priority: flush_req and timer expiry in the same cycle -> FLUSH query first, then MIG query, with no WAIT_TOPK after FLUSH.
- Timeout and clamp: no mig_en for 255 cycles -> IDLE, timeout_cnt=1; cfg_num_mig=7 -> num_mig=5.
- Reset mid-DRAIN: rstn asserted while mig_addr_valid=1 -> valid drops at once, all counters 0 after release.
